// File: rtl/line_ram.sv
// line_ram: Maria double-buffered 160-pixel line RAM.
// Unpacks DMA graphics bytes into the write buffer and streams the read buffer
// out one pixel per pclk0, clearing each entry as it is read.
// Optional feature macro: LINE_RAM_KANGAROO_EN (honour the kangaroo input).
module line_ram (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       mclk0,
  input  logic       pclk0,
  input  logic       lrc,
  input  logic       clear_hpos,
  input  logic       latch_byte,
  input  logic [7:0] DataB,
  input  logic [7:0] HPOS,
  input  logic [2:0] PAL,
  input  logic       WM,
  input  logic       kangaroo,
  output logic [4:0] pix,
  output logic       pix_valid,
  output logic       init_busy
);

  localparam int unsigned LINE_LEN = 160;
  localparam int unsigned ROWS     = LINE_LEN / 4;
  localparam logic [7:0]  LINE_END = 8'(LINE_LEN);
  localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);

  logic       wsel_q, wsel_d;
  logic [7:0] rptr_q, rptr_d;
  logic [7:0] wptr_q, wptr_d;
  logic       load_pending_q, load_pending_d;
  logic       init_busy_q, init_busy_d;
  logic [5:0] sweep_q, sweep_d;
  logic [4:0] pix_q, pix_d;
  logic       pix_valid_q, pix_valid_d;

  logic kang_en;
`ifdef LINE_RAM_KANGAROO_EN
  assign kang_en = kangaroo;
`else
  logic unused_kangaroo;
  assign unused_kangaroo = kangaroo;
  assign kang_en         = 1'b0;
`endif

  logic       active, swap, do_latch, do_read, rd_sel;
  logic [7:0] base, rd_addr;
  logic [5:0] rd_row;
  logic [4:0] bank_rd [4];
  logic [4:0] rd_data;

  assign active   = mclk0 & ~init_busy_q;
  assign swap     = active & lrc;
  assign do_latch = active & latch_byte & ~lrc;
  assign base     = load_pending_q ? HPOS : wptr_q;
  // A swap in the same cycle redirects the read to address 0 of the new read buffer
  assign rd_sel   = swap ? wsel_q : ~wsel_q;
  assign rd_addr  = swap ? '0 : rptr_q;
  assign do_read  = active & pclk0 & (rd_addr < LINE_END);
  assign rd_row   = do_read ? rd_addr[7:2] : '0;
  assign rd_data  = bank_rd[rd_addr[1:0]];

  for (genvar g = 0; g < 4; g++) begin : g_bank
    logic [1:0] idx;
    logic [7:0] pos;
    logic [1:0] c;
    logic [3:0] d;
    logic       opaque, in_range, wr_en;
    logic [4:0] wr_val;
    logic [4:0] mem_q [2][ROWS];

    // Which pixel of the current byte lands in this bank, and where
    assign idx = 2'(g) - base[1:0];
    assign pos = base + {6'd0, idx};

    // Pixel colour extraction for both write modes
    always_comb begin
      c = '0;
      d = '0;
      case (idx)
        2'd0: begin c = DataB[7:6]; d = {DataB[3:2], DataB[7:6]}; end
        2'd1: begin c = DataB[5:4]; d = {DataB[1:0], DataB[5:4]}; end
        2'd2: c = DataB[3:2];
        default: c = DataB[1:0];
      endcase
    end

    assign opaque   = WM ? (|d) : (|c);
    assign in_range = ~WM | ~idx[1];
    assign wr_val   = WM ? {PAL[2], d} : {PAL, c};
    assign wr_en    = do_latch & in_range & (pos < LINE_END) & (opaque | kang_en);
    assign bank_rd[g] = mem_q[rd_sel][rd_row];

    // Bank storage: init sweep, pixel writes, clear-on-read
    always_ff @(posedge clk_sys) begin
      if (mclk0) begin
        if (init_busy_q) begin
          mem_q[0][sweep_q] <= '0;
          mem_q[1][sweep_q] <= '0;
        end else begin
          if (wr_en) mem_q[wsel_q][pos[7:2]] <= wr_val;
          if (do_read && (rd_addr[1:0] == 2'(g))) mem_q[rd_sel][rd_row] <= '0;
        end
      end
    end
  end

  // Next-state for pointers, buffer select, init sweep and pixel output
  always_comb begin
    wsel_d         = wsel_q;
    rptr_d         = rptr_q;
    wptr_d         = wptr_q;
    load_pending_d = load_pending_q;
    init_busy_d    = init_busy_q;
    sweep_d        = sweep_q;
    pix_d          = '0;
    pix_valid_d    = 1'b0;
    if (init_busy_q) begin
      if (sweep_q == LAST_ROW) init_busy_d = 1'b0;
      else                     sweep_d     = sweep_q + 6'd1;
    end
    if (do_latch) begin
      load_pending_d = 1'b0;
      wptr_d         = base + (WM ? 8'd2 : 8'd4);
    end
    if (swap) begin
      wsel_d = ~wsel_q;
      rptr_d = '0;
    end
    if (clear_hpos | swap) load_pending_d = 1'b1;
    if (do_read) begin
      pix_d       = rd_data;
      pix_valid_d = 1'b1;
      rptr_d      = rd_addr + 8'd1;
    end
  end

  // Control registers, advanced only on mclk0
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wsel_q         <= 1'b0;
      rptr_q         <= LINE_END;
      wptr_q         <= '0;
      load_pending_q <= 1'b1;
      init_busy_q    <= 1'b1;
      sweep_q        <= '0;
      pix_q          <= '0;
      pix_valid_q    <= 1'b0;
    end else if (mclk0) begin
      wsel_q         <= wsel_d;
      rptr_q         <= rptr_d;
      wptr_q         <= wptr_d;
      load_pending_q <= load_pending_d;
      init_busy_q    <= init_busy_d;
      sweep_q        <= sweep_d;
      pix_q          <= pix_d;
      pix_valid_q    <= pix_valid_d;
    end
  end

  assign pix       = pix_q;
  assign pix_valid = pix_valid_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_line_ram.sv
// tb_line_ram: directed stimulus with a scoreboard queue for line readout.
module tb_line_ram;
  logic       clk_sys    = 1'b0;
  logic       reset      = 1'b1;
  logic       mclk0      = 1'b1;
  logic       pclk0      = 1'b0;
  logic       lrc        = 1'b0;
  logic       clear_hpos = 1'b0;
  logic       latch_byte = 1'b0;
  logic [7:0] DataB      = '0;
  logic [7:0] HPOS       = '0;
  logic [2:0] PAL        = '0;
  logic       WM         = 1'b0;
  logic       kangaroo   = 1'b0;
  logic [4:0] pix;
  logic       pix_valid;
  logic       init_busy;

  int compared   = 0;
  int mismatched = 0;
  int vcount     = 0;

  logic [12:0] expq [$];
  logic [4:0]  exp_wr [160] = '{default: '0};
  logic [4:0]  exp_rd [160] = '{default: '0};

`ifdef LINE_RAM_KANGAROO_EN
  localparam logic [4:0] KANG_X21 = 5'h10;
`else
  localparam logic [4:0] KANG_X21 = 5'h05;
`endif

  always #5 clk_sys = ~clk_sys;

  line_ram dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .mclk0     (mclk0),
    .pclk0     (pclk0),
    .lrc       (lrc),
    .clear_hpos(clear_hpos),
    .latch_byte(latch_byte),
    .DataB     (DataB),
    .HPOS      (HPOS),
    .PAL       (PAL),
    .WM        (WM),
    .kangaroo  (kangaroo),
    .pix       (pix),
    .pix_valid (pix_valid),
    .init_busy (init_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pop an expected pixel for every valid output, otherwise expect idle zeros
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (pix_valid === 1'b1) begin
        vcount++;
        compared++;
        if (expq.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_pix: got pix=%0h with no pixel expected", pix);
        end else begin
          logic [12:0] e;
          e = expq.pop_front();
          if (pix !== e[4:0]) begin
            mismatched++;
            $display("FAIL pix_x%0d: got %0h, expected %0h", e[12:5], pix, e[4:0]);
          end
        end
      end else begin
        compared++;
        if (pix_valid !== 1'b0 || pix !== 5'd0) begin
          mismatched++;
          $display("FAIL idle_out: got valid=%b pix=%0h, expected 0/0", pix_valid, pix);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input int x);
    expq.push_back({8'(x), exp_rd[x]});
  endtask

  task automatic header(input logic [7:0] hp, input logic [2:0] pal, input logic wm, input logic k);
    HPOS = hp; PAL = pal; WM = wm; kangaroo = k;
    clear_hpos = 1'b1;
    cyc();
    clear_hpos = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    DataB = d;
    latch_byte = 1'b1;
    cyc();
    latch_byte = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic swap_read(input bit with_pclk, input bit collide, input logic [7:0] cdata,
                           input string tag);
    exp_rd = exp_wr;
    exp_wr = '{default: '0};
    vcount = 0;
    lrc = 1'b1;
    latch_byte = collide;
    DataB = cdata;
    if (with_pclk) begin
      pclk0 = 1'b1;
      push(0);
    end
    cyc();
    lrc = 1'b0;
    latch_byte = 1'b0;
    for (int x = (with_pclk ? 1 : 0); x < 160; x++) begin
      pclk0 = 1'b1;
      push(x);
      cyc();
    end
    pclk0 = 1'b1;
    cyc();
    cyc();
    pclk0 = 1'b0;
    cyc();
    cyc();
    check({tag, "_count"}, vcount, 160);
    check({tag, "_drain"}, expq.size(), 0);
  endtask

  initial begin
    // Reset state and init sweep
    repeat (3) cyc();
    check("rst_pix", pix, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_busy", init_busy, 1);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      check("sweep_busy", init_busy, 1);
      cyc();
    end
    check("sweep_done", init_busy, 0);

    // Line 1: freshly swept buffer reads all zero
    swap_read(1'b0, 1'b0, 8'h00, "line1");

    // Line 2: clock-enable gating, 2 bpp, 4 bpp transparency, wrap, x50
    mclk0 = 1'b0;
    header(8'd100, 3'd7, 1'b0, 1'b0);
    send(8'hFF);
    mclk0 = 1'b1;
    header(8'd10, 3'd5, 1'b0, 1'b0);
    send(8'h1B);
    send(8'hE4);
    exp_wr[11] = 5'h15; exp_wr[12] = 5'h16; exp_wr[13] = 5'h17;
    exp_wr[14] = 5'h17; exp_wr[15] = 5'h16; exp_wr[16] = 5'h15;
    header(8'd20, 3'd1, 1'b0, 1'b0);
    send(8'h10);
    header(8'd20, 3'd6, 1'b1, 1'b0);
    send(8'hC0);
    exp_wr[20] = 5'h13; exp_wr[21] = 5'h05;
    header(8'd254, 3'd1, 1'b0, 1'b0);
    send(8'hFF);
    send(8'h55);
    exp_wr[0] = 5'h07; exp_wr[1] = 5'h07;
    exp_wr[2] = 5'h05; exp_wr[3] = 5'h05; exp_wr[4] = 5'h05; exp_wr[5] = 5'h05;
    header(8'd50, 3'd7, 1'b0, 1'b0);
    send(8'hC0);
    exp_wr[50] = 5'h1F;
    swap_read(1'b1, 1'b0, 8'h00, "line2");

    // Line 3: kangaroo transparency, then swap colliding with a byte
    header(8'd20, 3'd1, 1'b0, 1'b0);
    send(8'h10);
    header(8'd20, 3'd6, 1'b1, 1'b1);
    send(8'hC0);
    kangaroo = 1'b0;
    exp_wr[20] = 5'h13; exp_wr[21] = KANG_X21;
    header(8'd0, 3'd7, 1'b0, 1'b0);
    swap_read(1'b1, 1'b1, 8'hFF, "line3");

    // Line 4: no writes; line-2 buffer must have been cleared by its readout
    swap_read(1'b0, 1'b0, 8'h00, "line4");

    // Reset in the middle of a readout
    header(8'd30, 3'd3, 1'b0, 1'b0);
    send(8'hFF);
    exp_wr[30] = 5'h0F; exp_wr[31] = 5'h0F; exp_wr[32] = 5'h0F; exp_wr[33] = 5'h0F;
    exp_rd = exp_wr;
    exp_wr = '{default: '0};
    lrc = 1'b1;
    cyc();
    lrc = 1'b0;
    for (int x = 0; x < 30; x++) begin
      pclk0 = 1'b1;
      push(x);
      cyc();
    end
    #2;
    reset = 1'b1;
    #1;
    check("midrst_pix", pix, 0);
    check("midrst_valid", pix_valid, 0);
    check("midrst_busy", init_busy, 1);
    expq.delete();
    pclk0 = 1'b0;
    cyc();
    reset = 1'b0;
    repeat (10) cyc();
    HPOS = 8'd0; PAL = 3'd7; WM = 1'b0; DataB = 8'hFF;
    lrc = 1'b1; pclk0 = 1'b1; latch_byte = 1'b1;
    cyc();
    lrc = 1'b0; pclk0 = 1'b0; latch_byte = 1'b0;
    repeat (28) cyc();
    check("resweep_busy", init_busy, 1);
    cyc();
    check("resweep_done", init_busy, 0);
    exp_wr = '{default: '0};
    swap_read(1'b0, 1'b0, 8'h00, "post_rst_a");
    swap_read(1'b1, 1'b0, 8'h00, "post_rst_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
